// File: rtl/game_sequencer_if.sv
// Board-controller bus: game inputs from selectionStage/getColors and the
// display-write, status and counter outputs of game_sequencer.
interface game_sequencer_if;
    logic        start;
    logic        submitted;
    logic [2:0]  col;
    logic [6:0]  value;
    logic [34:0] scored_row;
    logic [1:0]  state;
    logic [2:0]  row;
    logic [6:0]  word_index;
    logic        letter_we;
    logic [2:0]  letter_col;
    logic [6:0]  letter_data;
    logic        row_we;
    logic [2:0]  row_wr;
    logic [34:0] row_data;
    logic        board_clr;
    logic        reject;
    logic [7:0]  wins;

    // Environment side: drives game inputs, observes controller outputs
    modport master (
        output start, submitted, col, value, scored_row,
        input  state, row, word_index, letter_we, letter_col, letter_data,
               row_we, row_wr, row_data, board_clr, reject, wins
    );

    // Controller side
    modport slave (
        input  start, submitted, col, value, scored_row,
        output state, row, word_index, letter_we, letter_col, letter_data,
               row_we, row_wr, row_data, board_clr, reject, wins
    );
endinterface

// File: rtl/game_sequencer.sv
// Wordle game controller: word selection, guess-row sequencing, win/loss detection.
// Optional win counter enabled by defining GAME_SEQ_WINS_EN.
module game_sequencer #(
    parameter int unsigned NUM_ROWS    = 6,
    parameter int unsigned NUM_WORDS   = 100,
    parameter int unsigned HOLD_CYCLES = 200
) (
    input  logic            logicclk,
    input  logic            clr,
    game_sequencer_if.slave bus
);
    localparam int unsigned     HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0]      LAST_ROW  = 3'(NUM_ROWS - 1);
    localparam logic [6:0]      LAST_WORD = 7'(NUM_WORDS - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        SELECT_WORD  = 2'b00,
        EDIT_LETTER  = 2'b01,
        DISPLAY_WIN  = 2'b10,
        DISPLAY_LOSE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [6:0]        widx_q, widx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              letter_we_q, letter_we_d;
    logic [2:0]        letter_col_q, letter_col_d;
    logic [6:0]        letter_data_q, letter_data_d;
    logic              row_we_q, row_we_d;
    logic [2:0]        row_wr_q, row_wr_d;
    logic [34:0]       row_data_q, row_data_d;
    logic              board_clr_q, board_clr_d;
    logic              reject_q, reject_d;
    logic              blank_c, green_c;

    // Row scan: any blank letter code refuses the row; all-green wins it
    always_comb begin
        blank_c = 1'b0;
        green_c = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.scored_row[7*i +: 5] == 5'd0) blank_c = 1'b1;
            if (bus.scored_row[7*i+5 +: 2] != 2'b11) green_c = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        widx_d        = widx_q;
        hold_d        = hold_q;
        letter_we_d   = 1'b0;
        letter_col_d  = letter_col_q;
        letter_data_d = letter_data_q;
        row_we_d      = 1'b0;
        row_wr_d      = row_wr_q;
        row_data_d    = row_data_q;
        board_clr_d   = 1'b0;
        reject_d      = 1'b0;
        case (state_q)
            SELECT_WORD: begin
                if (bus.start) state_d = EDIT_LETTER;
                else           widx_d  = (widx_q == LAST_WORD) ? 7'd0 : widx_q + 7'd1;
            end
            EDIT_LETTER: begin
                if (bus.submitted) begin
                    if (blank_c) begin
                        reject_d = 1'b1;
                    end else begin
                        row_we_d   = 1'b1;
                        row_wr_d   = row_q;
                        row_data_d = bus.scored_row;
                        hold_d     = '0;
                        if (green_c)              state_d = DISPLAY_WIN;
                        else if (row_q == LAST_ROW) state_d = DISPLAY_LOSE;
                        else                      row_d   = row_q + 3'd1;
                    end
                end else if (bus.col <= 3'd4) begin
                    letter_we_d   = 1'b1;
                    letter_col_d  = bus.col;
                    letter_data_d = bus.value;
                end
            end
            default: begin
                // Result dwell; board clears as SELECT_WORD is entered
                if (hold_q == LAST_HOLD) begin
                    state_d     = SELECT_WORD;
                    board_clr_d = 1'b1;
                    row_d       = 3'd0;
                    hold_d      = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge logicclk or posedge clr) begin
        if (clr) begin
            state_q       <= SELECT_WORD;
            row_q         <= 3'd0;
            widx_q        <= 7'd0;
            hold_q        <= '0;
            letter_we_q   <= 1'b0;
            letter_col_q  <= 3'd0;
            letter_data_q <= 7'd0;
            row_we_q      <= 1'b0;
            row_wr_q      <= 3'd0;
            row_data_q    <= 35'd0;
            board_clr_q   <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            widx_q        <= widx_d;
            hold_q        <= hold_d;
            letter_we_q   <= letter_we_d;
            letter_col_q  <= letter_col_d;
            letter_data_q <= letter_data_d;
            row_we_q      <= row_we_d;
            row_wr_q      <= row_wr_d;
            row_data_q    <= row_data_d;
            board_clr_q   <= board_clr_d;
            reject_q      <= reject_d;
        end
    end

`ifdef GAME_SEQ_WINS_EN
    logic [7:0] wins_q;

    // Saturating count of game wins
    always_ff @(posedge logicclk or posedge clr) begin
        if (clr)
            wins_q <= 8'd0;
        else if (state_q == EDIT_LETTER && state_d == DISPLAY_WIN && wins_q != 8'hFF)
            wins_q <= wins_q + 8'd1;
    end

    assign bus.wins = wins_q;
`else
    assign bus.wins = 8'h00;
`endif

    assign bus.state       = state_q;
    assign bus.row         = row_q;
    assign bus.word_index  = widx_q;
    assign bus.letter_we   = letter_we_q;
    assign bus.letter_col  = letter_col_q;
    assign bus.letter_data = letter_data_q;
    assign bus.row_we      = row_we_q;
    assign bus.row_wr      = row_wr_q;
    assign bus.row_data    = row_data_q;
    assign bus.board_clr   = board_clr_q;
    assign bus.reject      = reject_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand-written multi-cycle
// sequences and randomized play against a behavioural game model.
module tb_game_sequencer;
    localparam int unsigned NUM_ROWS    = 6;
    localparam int unsigned NUM_WORDS   = 100;
    localparam int unsigned HOLD_CYCLES = 200;
`ifdef GAME_SEQ_WINS_EN
    localparam bit WINS_EN = 1'b1;
`else
    localparam bit WINS_EN = 1'b0;
`endif

    localparam logic [34:0] WIN_ROW    = {5{7'h61}};
    localparam logic [34:0] NONWIN_ROW = {7'h25, 7'h63, 7'h22, 7'h41, 7'h61};
    localparam logic [34:0] BLANK3_ROW = {7'h61, 7'h60, 7'h61, 7'h61, 7'h61};

    logic logicclk = 1'b0;
    logic clr;
    game_sequencer_if bus();

    game_sequencer #(
        .NUM_ROWS(NUM_ROWS), .NUM_WORDS(NUM_WORDS), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .logicclk(logicclk),
        .clr(clr),
        .bus(bus)
    );

    always #5 logicclk = ~logicclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge logicclk);
        #1;
    endtask

    task automatic drive(input logic s, input logic sub, input logic [2:0] c,
                         input logic [6:0] v, input logic [34:0] sr);
        bus.start      = s;
        bus.submitted  = sub;
        bus.col        = c;
        bus.value      = v;
        bus.scored_row = sr;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 64'(bus.state), 64'd0);
        chk({tag, "_row"},   64'(bus.row), 64'd0);
        chk({tag, "_widx"},  64'(bus.word_index), 64'd0);
        chk({tag, "_pulses"}, 64'({bus.letter_we, bus.row_we, bus.board_clr, bus.reject}), 64'd0);
        chk({tag, "_data"},  64'({bus.letter_col, bus.letter_data, bus.row_wr}), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.row_data), 64'd0);
        chk({tag, "_wins"},  64'(bus.wins), 64'd0);
    endtask

    // Directed table: starts in EDIT_LETTER at row 0
    typedef struct {
        logic        start, sub;
        logic [2:0]  col;
        logic [6:0]  value;
        logic [34:0] scored;
        logic [1:0]  e_state;
        logic [2:0]  e_row;
        logic        e_lwe;
        logic [2:0]  e_lcol;
        logic [6:0]  e_ldat;
        logic        e_rwe;
        logic [2:0]  e_rwr;
        logic        e_rej;
    } vec_t;
    vec_t tbl [8];

    // Behavioural model: game phase, guesses used, dwell countdown
    int unsigned m_phase, m_row, m_idx, m_dwell, m_wins;
    logic        m_lwe, m_rwe, m_bclr, m_rej;
    logic [2:0]  m_lcol, m_rwr;
    logic [6:0]  m_ldat;
    logic [34:0] m_rdata;

    task automatic model_step(input logic s, input logic sub, input logic [2:0] c,
                              input logic [6:0] v, input logic [34:0] sr);
        bit any_blank = 1'b0;
        bit all_green = 1'b1;
        logic [6:0] lt;
        m_lwe = 1'b0; m_rwe = 1'b0; m_bclr = 1'b0; m_rej = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lt = sr[7*k +: 7];
            if (lt[4:0] == 5'd0) any_blank = 1'b1;
            if (lt[6:5] != 2'b11) all_green = 1'b0;
        end
        if (m_phase == 0) begin
            if (s) m_phase = 1;
            else   m_idx = (m_idx + 1) % NUM_WORDS;
        end else if (m_phase == 1) begin
            if (sub) begin
                if (any_blank) m_rej = 1'b1;
                else begin
                    m_rwe = 1'b1; m_rwr = 3'(m_row); m_rdata = sr;
                    if (all_green) begin
                        m_phase = 2; m_dwell = HOLD_CYCLES;
                        if (WINS_EN && m_wins < 255) m_wins++;
                    end else if (m_row == NUM_ROWS - 1) begin
                        m_phase = 3; m_dwell = HOLD_CYCLES;
                    end else m_row++;
                end
            end else if (c < 3'd5) begin
                m_lwe = 1'b1; m_lcol = c; m_ldat = v;
            end
        end else begin
            m_dwell--;
            if (m_dwell == 0) begin
                m_phase = 0; m_bclr = 1'b1; m_row = 0;
            end
        end
    endtask

    function automatic logic [34:0] rand_row();
        logic [34:0] r = '0;
        int unsigned kind = $urandom_range(0, 2);
        int unsigned code, color;
        for (int k = 0; k < 5; k++) begin
            code  = (kind == 1 && $urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 26);
            color = (kind == 0) ? 3 : $urandom_range(0, 3);
            r[7*k +: 7] = {2'(color), 5'(code)};
        end
        return r;
    endfunction

    initial begin
        int cyc;
        logic [6:0] frozen;
        tbl[0] = '{1'b0, 1'b0, 3'd2, 7'h03, 35'd0,       2'b01, 3'd0, 1'b1, 3'd2, 7'h03, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 3'd5, 7'h11, 35'd0,       2'b01, 3'd0, 1'b0, 3'd0, 7'h00, 1'b0, 3'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 3'd4, 7'h1A, 35'd0,       2'b01, 3'd0, 1'b1, 3'd4, 7'h1A, 1'b0, 3'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 3'd1, 7'h05, BLANK3_ROW,  2'b01, 3'd0, 1'b0, 3'd0, 7'h00, 1'b0, 3'd0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 3'd1, 7'h05, NONWIN_ROW,  2'b01, 3'd1, 1'b0, 3'd0, 7'h00, 1'b1, 3'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 3'd1, 7'h05, NONWIN_ROW,  2'b01, 3'd2, 1'b0, 3'd0, 7'h00, 1'b1, 3'd1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 3'd1, 7'h05, WIN_ROW,     2'b10, 3'd2, 1'b0, 3'd0, 7'h00, 1'b1, 3'd2, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 3'd0, 7'h07, NONWIN_ROW,  2'b10, 3'd2, 1'b0, 3'd0, 7'h00, 1'b0, 3'd0, 1'b0};

        clr = 1'b1;
        drive(1'b0, 1'b0, 3'd7, 7'd0, 35'd0);
        tick();
        check_reset("reset");
        clr = 1'b0;

        // Word index free-runs and wraps in SELECT_WORD
        for (int k = 1; k <= 105; k++) begin
            tick();
            chk($sformatf("widx_run%0d", k), 64'(bus.word_index), 64'(k % NUM_WORDS));
        end
        drive(1'b1, 1'b0, 3'd7, 7'd0, 35'd0);
        tick();
        chk("start_state", 64'(bus.state), 64'd1);
        chk("start_widx", 64'(bus.word_index), 64'd5);
        frozen = bus.word_index;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 3'd7, 7'd0, 35'd0);
            tick();
            chk($sformatf("freeze%0d", k), 64'({bus.word_index, bus.letter_we}), 64'({7'd5, 1'b0}));
        end

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].start, tbl[i].sub, tbl[i].col, tbl[i].value, tbl[i].scored);
            tick();
            chk($sformatf("tbl%0d_state", i), 64'(bus.state), 64'(tbl[i].e_state));
            chk($sformatf("tbl%0d_row", i), 64'(bus.row), 64'(tbl[i].e_row));
            chk($sformatf("tbl%0d_pulses", i), 64'({bus.letter_we, bus.row_we, bus.reject, bus.board_clr}),
                64'({tbl[i].e_lwe, tbl[i].e_rwe, tbl[i].e_rej, 1'b0}));
            if (tbl[i].e_lwe)
                chk($sformatf("tbl%0d_letter", i), 64'({bus.letter_col, bus.letter_data}),
                    64'({tbl[i].e_lcol, tbl[i].e_ldat}));
            if (tbl[i].e_rwe) begin
                chk($sformatf("tbl%0d_rowwr", i), 64'(bus.row_wr), 64'(tbl[i].e_rwr));
                chk($sformatf("tbl%0d_rowdata", i), 64'(bus.row_data), 64'(tbl[i].scored));
            end
        end
        chk("edit_widx_frozen", 64'(bus.word_index), 64'(frozen));

        // Win dwell: state entered at tbl[6], tbl[7] was the second result cycle
        drive(1'b0, 1'b0, 3'd7, 7'd0, 35'd0);
        cyc = 1;
        while (bus.state != 2'b00 && cyc < int'(HOLD_CYCLES) + 10) begin
            tick();
            cyc++;
        end
        chk("win_dwell", 64'(cyc), 64'(HOLD_CYCLES));
        chk("win_clr", 64'({bus.board_clr, bus.row, bus.state}), 64'({1'b1, 3'd0, 2'd0}));
        chk("win_count", 64'(bus.wins), 64'(WINS_EN ? 1 : 0));

        drive(1'b0, 1'b1, 3'd7, 7'd0, NONWIN_ROW);
        tick();
        chk("select_submit_ignored", 64'({bus.state, bus.row_we, bus.reject, bus.board_clr}), 64'd0);

        // Loss: six non-winning guesses
        drive(1'b1, 1'b0, 3'd7, 7'd0, 35'd0);
        tick();
        chk("loss_start", 64'({bus.state, bus.row}), 64'({2'b01, 3'd0}));
        for (int r = 0; r < 6; r++) begin
            drive(1'b0, 1'b1, 3'd7, 7'd0, NONWIN_ROW);
            tick();
            chk($sformatf("loss_sub%0d_we", r), 64'({bus.row_we, bus.row_wr}), 64'({1'b1, 3'(r)}));
            chk($sformatf("loss_sub%0d_st", r), 64'({bus.state, bus.row}),
                (r < 5) ? 64'({2'b01, 3'(r + 1)}) : 64'({2'b11, 3'd5}));
            drive(1'b0, 1'b0, 3'd7, 7'd0, 35'd0);
            tick();
            chk($sformatf("loss_idle%0d", r), 64'({bus.row_we, bus.row}), 64'({1'b0, 3'(r < 5 ? r + 1 : 5)}));
        end
        cyc = 1;
        while (bus.state != 2'b00 && cyc < int'(HOLD_CYCLES) + 10) begin
            tick();
            cyc++;
        end
        chk("lose_dwell", 64'(cyc), 64'(HOLD_CYCLES));
        chk("lose_clr", 64'({bus.board_clr, bus.row}), 64'({1'b1, 3'd0}));
        chk("lose_wins", 64'(bus.wins), 64'(WINS_EN ? 1 : 0));

        // Async clear in the middle of DISPLAY_WIN
        drive(1'b1, 1'b0, 3'd7, 7'd0, 35'd0);
        tick();
        drive(1'b0, 1'b1, 3'd7, 7'd0, WIN_ROW);
        tick();
        chk("async_pre_state", 64'(bus.state), 64'd2);
        drive(1'b0, 1'b0, 3'd7, 7'd0, 35'd0);
        tick();
        tick();
        #2 clr = 1'b1;
        #1 check_reset("async");

        // Randomized play against the model
        tick();
        clr = 1'b0;
        m_phase = 0; m_row = 0; m_idx = 0; m_dwell = 0; m_wins = 0;
        m_lcol = '0; m_ldat = '0; m_rwr = '0; m_rdata = '0;
        for (int n = 0; n < 4000; n++) begin
            logic s, sub;
            logic [2:0] c;
            logic [6:0] v;
            logic [34:0] sr;
            s   = ($urandom_range(0, 7) == 0);
            sub = ($urandom_range(0, 3) == 0);
            c   = 3'($urandom_range(0, 7));
            v   = 7'($urandom);
            sr  = rand_row();
            drive(s, sub, c, v, sr);
            model_step(s, sub, c, v, sr);
            tick();
            chk("rand_state", 64'(bus.state), 64'(m_phase));
            chk("rand_row", 64'(bus.row), 64'(m_row));
            chk("rand_widx", 64'(bus.word_index), 64'(m_idx));
            chk("rand_pulses", 64'({bus.letter_we, bus.row_we, bus.board_clr, bus.reject}),
                64'({m_lwe, m_rwe, m_bclr, m_rej}));
            chk("rand_wins", 64'(bus.wins), 64'(m_wins));
            if (m_lwe)
                chk("rand_letter", 64'({bus.letter_col, bus.letter_data}), 64'({m_lcol, m_ldat}));
            if (m_rwe) begin
                chk("rand_rowwr", 64'(bus.row_wr), 64'(m_rwr));
                chk("rand_rowdata", 64'(bus.row_data), 64'(m_rdata));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
